biriscv_alu_issue: RTL and testbench
====================================

# biriscv_alu_issue

Issue-side controller and result collector for the 2-stage pipelined ALU. It accepts ALU operations from the dispatch stage over a valid/ready handshake and drives the ALU's operand inputs. Results return exactly two cycles later with no backpressure, so the block reserves a result slot before issuing. It pairs each returning result with its destination register, buffers it, and presents it to writeback over a valid/ready handshake, stalling dispatch on RAW hazards against any unretired destination.

## Interface
- DEPTH, 4: outstanding-operation slots (in-flight plus buffered); legal range 2..8, power of two.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- issue_valid_i  in  1  dispatch offers an operation.
- issue_ready_o  out  1  block accepts the operation this cycle.
- issue_op_i  in  4  ALU opcode (ALU_* encoding).
- issue_a_i, issue_b_i  in  32 each  operands.
- issue_rd_i  in  5  destination register.
- issue_rs1_i, issue_rs2_i  in  5 each  source registers of the offered op, for the hazard check.
- alu_valid_o  out  1  to ALU valid_i.
- alu_op_o  out  4  to ALU alu_op_i.
- alu_a_o, alu_b_o  out  32 each  to ALU alu_a_i / alu_b_i.
- alu_valid_i  in  1  from ALU valid_o.
- alu_p_i  in  32  from ALU alu_p_o.
- wb_valid_o  out  1  result available.
- wb_ready_i  in  1  writeback accepts.
- wb_rd_o  out  5  destination of the head result.
- wb_value_o  out  32  head result value.
- err_o  out  1  sticky protocol error.

## Operation
- Tag FIFO (DEPTH x 5 bits): written with issue_rd_i on issue fire (issue_valid_i & issue_ready_o); popped on writeback fire (wb_valid_o & wb_ready_i). Its occupancy tag_cnt (0..DEPTH) counts every unretired operation.
- Result FIFO (DEPTH x 32 bits): written with alu_p_i when alu_valid_i is accepted; popped on writeback fire. Occupancy res_cnt is always <= tag_cnt.
- Results return in issue order, so the result FIFO head always pairs with the tag FIFO head.
- issue_ready_o = (tag_cnt < DEPTH) & ~hazard & ~drain. A pop in the same cycle does not free a slot for that cycle's issue.
- hazard: asserted when issue_rs1_i or issue_rs2_i is nonzero and equals any valid tag FIFO entry. The check is conservative: an entry being popped this cycle still counts.
- rd = 0: the operation occupies a slot and is written back normally, but x0 never causes a hazard.
- ALU drive is combinational: alu_valid_o = issue fire; alu_op_o, alu_a_o and alu_b_o pass the issue_* fields straight through.
- wb_valid_o = res_cnt != 0. wb_rd_o and wb_value_o are the FIFO heads. They must hold stable while wb_valid_o & ~wb_ready_i.
- Drain: for the 2 cycles after rst_i deasserts, drain is high. During drain, alu_valid_i is ignored (stale ALU pipeline contents) and issue_ready_o is 0.
- err_o is set when alu_valid_i is accepted while res_cnt == tag_cnt (a result with no outstanding tag); the result is discarded. err_o clears only on reset.

## Timing
- Reset values: issue_ready_o 0 during reset and drain; alu_valid_o 0; wb_valid_o 0; err_o 0; both FIFOs empty. Pointers wrap modulo DEPTH.
- Cycle 0: issue fire. Cycle 2: alu_valid_i high, result written at the end of the cycle. Cycle 3: wb_valid_o high. Issue to writeback is 3 cycles.
- Throughput is one op per cycle while wb_ready_i is held high; DEPTH >= 4 is required for continuous issue without stalls.
- A dependent op stalls until its producer's writeback fire, then issues the next cycle. Back-to-back RAW pairs cost 3 stall cycles.
- Simultaneous FIFO push and pop at the same occupancy leaves the count unchanged. A pop with res_cnt == 0 cannot occur because wb_valid_o is 0.
- Reset mid-operation discards all buffered and in-flight operations. Dispatch must replay them.

## Test plan
- Reset then single ADD: a=5, b=7, rd=3 issued in the first cycle after drain -> alu_valid_o 1 that cycle; wb_valid_o 3 cycles later with wb_rd_o=3, wb_value_o=12; err_o stays 0.
- Stream of 8 independent ops with distinct rd, wb_ready_i=1 -> issue_ready_o never drops; writebacks appear in issue order at 1 per cycle.
- wb_ready_i=0 with DEPTH=4 -> exactly 4 ops accepted, then issue_ready_o=0. wb_ready_i=1 -> one pop per cycle, and issue resumes the cycle after the first pop.
- RAW: op1 rd=5, op2 rs1=5 offered the next cycle -> op2 stalls until op1's writeback fire and issues one cycle later. A rs1=0 variant issues without a stall.
- Unsolicited alu_valid_i with no outstanding op -> err_o=1 next cycle and remains set; result FIFO unchanged.
- Assert rst_i for 1 cycle with 3 ops outstanding -> wb_valid_o=0, issue_ready_o=0 for 2 drain cycles; ALU results arriving during drain are dropped with err_o=0.

Source files
------------

// File: rtl/biriscv_alu_issue.sv
// Issue-side controller and result collector for the 2-stage pipelined ALU.
// Reserves a result slot per issued op, pairs results with rd and stalls dispatch on RAW hazards.
module biriscv_alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [3:0]  issue_op_i,
    input  logic [31:0] issue_a_i,
    input  logic [31:0] issue_b_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  issue_rs1_i,
    input  logic [4:0]  issue_rs2_i,

    output logic        alu_valid_o,
    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic        alu_valid_i,
    input  logic [31:0] alu_p_i,

    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_value_o,

    output logic        err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    tag_mem_q [DEPTH];
    logic [31:0]   res_mem_q [DEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d, res_cnt_q, res_cnt_d;
    logic [1:0]    drain_q, drain_d;
    logic          err_q, err_d;

    logic          drain;
    logic          hazard;
    logic          issue_fire;
    logic          wb_fire;
    logic          res_push;
    logic          res_orphan;
    logic [PW-1:0] slot_off [DEPTH];

    assign drain = (drain_q != 2'd0);

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off[i] = PW'(i) - tag_rd_q;
            if ({1'b0, slot_off[i]} < tag_cnt_q) begin
                if ((issue_rs1_i != 5'd0 && issue_rs1_i == tag_mem_q[i]) ||
                    (issue_rs2_i != 5'd0 && issue_rs2_i == tag_mem_q[i])) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign issue_ready_o = ~rst_i & ~drain & ~hazard & (tag_cnt_q < CW'(DEPTH));
    assign issue_fire    = issue_valid_i & issue_ready_o;

    assign alu_valid_o = issue_fire;
    assign alu_op_o    = issue_op_i;
    assign alu_a_o     = issue_a_i;
    assign alu_b_o     = issue_b_i;

    assign wb_valid_o = (res_cnt_q != '0);
    assign wb_fire    = wb_valid_o & wb_ready_i;
    assign wb_rd_o    = tag_mem_q[tag_rd_q];
    assign wb_value_o = res_mem_q[res_rd_q];
    assign err_o      = err_q;

    // Results arriving while draining belong to ops issued before reset.
    assign res_push   = alu_valid_i & ~drain & (res_cnt_q != tag_cnt_q);
    assign res_orphan = alu_valid_i & ~drain & (res_cnt_q == tag_cnt_q);

    always_comb begin
        tag_wr_d  = tag_wr_q + PW'(issue_fire);
        tag_rd_d  = tag_rd_q + PW'(wb_fire);
        res_wr_d  = res_wr_q + PW'(res_push);
        res_rd_d  = res_rd_q + PW'(wb_fire);
        tag_cnt_d = tag_cnt_q + CW'(issue_fire) - CW'(wb_fire);
        res_cnt_d = res_cnt_q + CW'(res_push) - CW'(wb_fire);
        err_d     = err_q | res_orphan;
        drain_d   = drain ? (drain_q - 2'd1) : drain_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            tag_cnt_q <= '0;
            res_cnt_q <= '0;
            err_q     <= 1'b0;
            drain_q   <= 2'd2;
        end else begin
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            tag_cnt_q <= tag_cnt_d;
            res_cnt_q <= res_cnt_d;
            err_q     <= err_d;
            drain_q   <= drain_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue_fire) begin
            tag_mem_q[tag_wr_q] <= issue_rd_i;
        end
        if (res_push && !rst_i) begin
            res_mem_q[res_wr_q] <= alu_p_i;
        end
    end

endmodule

// File: tb/tb_biriscv_alu_issue.sv
// Randomized bench for biriscv_alu_issue: an emulated 2-cycle ALU feeds the DUT and an
// in-order queue of unretired ops predicts readiness, writeback order, values and errors.
module tb_biriscv_alu_issue;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [3:0]  issue_op_i;
    logic [31:0] issue_a_i;
    logic [31:0] issue_b_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  issue_rs1_i;
    logic [4:0]  issue_rs2_i;
    logic        alu_valid_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_valid_i;
    logic [31:0] alu_p_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_value_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    biriscv_alu_issue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_op_i(issue_op_i), .issue_a_i(issue_a_i), .issue_b_i(issue_b_i),
        .issue_rd_i(issue_rd_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .alu_valid_o(alu_valid_o), .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_valid_i(alu_valid_i), .alu_p_i(alu_p_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_value_o(wb_value_o),
        .err_o(err_o)
    );

    typedef struct {
        int          t;
        logic [4:0]  rd;
        logic [31:0] v;
    } ent_t;

    ent_t mq[$];
    int   cyc = 0;
    int   drain_left = 2;
    int   n_vec = 0;
    int   n_err = 0;
    bit   err_exp = 1'b0;

    bit          dut_fire;
    bit          obs_ready, obs_wbv, obs_err;
    logic [4:0]  obs_rd;
    logic [31:0] obs_val;

    logic        s0_v = 1'b0, s1_v = 1'b0;
    logic [3:0]  s0_op = 4'd0;
    logic [31:0] s0_a = 32'd0, s0_b = 32'd0, s1_p = 32'd0;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        return (op == 4'd0) ? (a + b) : ((a ^ b) + {28'd0, op});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        bit haz;
        haz = 1'b0;
        if (rst_i || drain_left != 0 || mq.size() >= DEPTH) return 1'b0;
        foreach (mq[i]) begin
            if ((issue_rs1_i != 5'd0 && mq[i].rd == issue_rs1_i) ||
                (issue_rs2_i != 5'd0 && mq[i].rd == issue_rs2_i)) haz = 1'b1;
        end
        return !haz;
    endfunction

    task automatic step();
        bit   r_exp, wbv_exp, iss, pop, legit;
        ent_t e;
        @(negedge clk_i);
        r_exp   = model_ready();
        wbv_exp = (mq.size() > 0) && (mq[0].t + 3 <= cyc);
        check("issue_ready", issue_ready_o, r_exp);
        check("alu_valid", alu_valid_o, issue_valid_i && r_exp);
        check("alu_op", alu_op_o, issue_op_i);
        check("alu_a", alu_a_o, issue_a_i);
        check("alu_b", alu_b_o, issue_b_i);
        check("wb_valid", wb_valid_o, wbv_exp);
        if (wbv_exp) begin
            check("wb_rd", wb_rd_o, mq[0].rd);
            check("wb_value", wb_value_o, mq[0].v);
        end
        check("err", err_o, err_exp);
        dut_fire  = issue_valid_i && issue_ready_o;
        obs_ready = issue_ready_o;
        obs_wbv   = wb_valid_o;
        obs_err   = err_o;
        obs_rd    = wb_rd_o;
        obs_val   = wb_value_o;
        s0_v  = alu_valid_o;
        s0_op = alu_op_o;
        s0_a  = alu_a_o;
        s0_b  = alu_b_o;
        iss   = issue_valid_i && r_exp;
        pop   = wbv_exp && wb_ready_i;
        legit = 1'b0;
        foreach (mq[i]) if (mq[i].t + 2 == cyc) legit = 1'b1;
        @(posedge clk_i);
        if (rst_i) begin
            mq.delete();
            drain_left = 2;
            err_exp    = 1'b0;
        end else begin
            if (alu_valid_i && drain_left == 0 && !legit) err_exp = 1'b1;
            if (drain_left > 0) drain_left--;
            if (pop) void'(mq.pop_front());
            if (iss) begin
                e.t  = cyc;
                e.rd = issue_rd_i;
                e.v  = alu_fn(issue_op_i, issue_a_i, issue_b_i);
                mq.push_back(e);
            end
        end
        cyc++;
        #1;
        alu_valid_i = s1_v;
        alu_p_i     = s1_p;
        s1_v = s0_v;
        s1_p = alu_fn(s0_op, s0_a, s0_b);
    endtask

    task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid_i = 1'b1;
        issue_op_i    = op;
        issue_a_i     = a;
        issue_b_i     = b;
        issue_rd_i    = rd;
        issue_rs1_i   = rs1;
        issue_rs2_i   = rs2;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        issue_rs1_i   = 5'd0;
        issue_rs2_i   = 5'd0;
    endtask

    int fires;
    int t1;
    int t2;

    initial begin
        rst_i = 1'b1; wb_ready_i = 1'b1; alu_valid_i = 1'b0; alu_p_i = 32'd0;
        issue_op_i = 4'd0; issue_a_i = 32'd0; issue_b_i = 32'd0; issue_rd_i = 5'd0;
        idle();
        step(); step();
        check("rst_ready", obs_ready, 1'b0);
        check("rst_wbv", obs_wbv, 1'b0);
        check("rst_err", obs_err, 1'b0);
        rst_i = 1'b0;
        step(); step();

        // Single ADD right after drain, 3-cycle issue-to-writeback.
        offer(4'd0, 32'd5, 32'd7, 5'd3, 5'd0, 5'd0);
        step();
        check("add_fire", dut_fire, 1'b1);
        idle();
        step(); step();
        check("add_early", obs_wbv, 1'b0);
        step();
        check("add_wbv", obs_wbv, 1'b1);
        check("add_rd", obs_rd, 5'd3);
        check("add_val", obs_val, 32'd12);
        repeat (3) step();

        fires = 0;
        for (int i = 0; i < 8; i++) begin
            offer(4'($urandom), $urandom, $urandom, 5'(i + 1), 5'd0, 5'd0);
            step();
            fires += int'(dut_fire);
        end
        check("stream_fires", fires, 8);
        idle();
        repeat (6) step();

        // Backpressure fills all slots.
        wb_ready_i = 1'b0;
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            offer(4'($urandom), $urandom, $urandom, 5'(i + 10), 5'd0, 5'd0);
            step();
            fires += int'(dut_fire);
        end
        check("full_fires", fires, DEPTH);
        check("full_ready", obs_ready, 1'b0);
        wb_ready_i = 1'b1;
        step();
        check("pop_nofree", dut_fire, 1'b0);
        step();
        check("resume", dut_fire, 1'b1);
        idle();
        repeat (8) step();

        // RAW stall and x0 variant.
        offer(4'd1, $urandom, $urandom, 5'd5, 5'd0, 5'd0);
        step();
        t1 = cyc - 1;
        offer(4'd2, $urandom, $urandom, 5'd6, 5'd5, 5'd0);
        t2 = -1;
        for (int i = 0; i < 20 && t2 < 0; i++) begin
            step();
            if (dut_fire) t2 = cyc - 1;
        end
        check("raw_gap", t2 - t1, 4);
        idle();
        repeat (6) step();
        offer(4'd1, $urandom, $urandom, 5'd5, 5'd0, 5'd0);
        step();
        offer(4'd2, $urandom, $urandom, 5'd6, 5'd0, 5'd0);
        step();
        check("x0_nostall", dut_fire, 1'b1);
        idle();
        repeat (6) step();

        // Unsolicited result.
        alu_valid_i = 1'b1;
        alu_p_i     = 32'hdead_beef;
        step();
        step();
        check("err_set", obs_err, 1'b1);
        repeat (3) step();
        check("err_sticky", obs_err, 1'b1);
        check("err_nowb", obs_wbv, 1'b0);

        // Reset with three outstanding ops.
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(4'($urandom), $urandom, $urandom, 5'(i + 20), 5'd0, 5'd0);
            step();
        end
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        check("drain1_ready", obs_ready, 1'b0);
        check("drain1_wbv", obs_wbv, 1'b0);
        step();
        check("drain2_ready", obs_ready, 1'b0);
        check("drain2_wbv", obs_wbv, 1'b0);
        step();
        check("post_drain_ready", obs_ready, 1'b1);
        check("post_drain_err", obs_err, 1'b0);
        check("post_drain_wbv", obs_wbv, 1'b0);
        wb_ready_i = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rst_i      = ($urandom_range(0, 299) == 0);
            wb_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7)
                offer(4'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            else
                idle();
            step();
        end
        rst_i = 1'b0;
        idle();
        wb_ready_i = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
